// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - memory read, instruction handshake and redirect signals of the fetch stage
interface fetch_unit_if;
    logic [7:0] mem_addr;
    logic [7:0] mem_rd_data;
    logic       instr_valid;
    logic       instr_ready;
    logic [7:0] instr_op;
    logic [7:0] instr_imm;
    logic [7:0] instr_pc;
    logic       instr_len;
    logic       jmp_en;
    logic [7:0] jmp_addr;

    modport master (
        output mem_addr,
        output instr_valid,
        output instr_op,
        output instr_imm,
        output instr_pc,
        output instr_len,
        input  mem_rd_data,
        input  instr_ready,
        input  jmp_en,
        input  jmp_addr
    );

    modport slave (
        input  mem_addr,
        input  instr_valid,
        input  instr_op,
        input  instr_imm,
        input  instr_pc,
        input  instr_len,
        output mem_rd_data,
        output instr_ready,
        output jmp_en,
        output jmp_addr
    );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage; define FETCH_IMM_EN for two-byte (bit 7 opcode) instructions
module fetch_unit #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus
);

    typedef enum logic [2:0] {
        F_OP  = 3'd0,
        L_OP  = 3'd1,
`ifdef FETCH_IMM_EN
        F_IMM = 3'd2,
        L_IMM = 3'd3,
`endif
        VALID = 3'd4
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [7:0] pc;
    logic [7:0] op_q;
    logic [7:0] pc_q;
`ifdef FETCH_IMM_EN
    logic [7:0] imm_q;
    logic       len_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= F_OP;
        end else begin
            state <= state_next;
        end
    end

    // A redirect overrides every state, including a completing handshake in VALID.
    always_comb begin
        state_next = state;
        if (bus.jmp_en) begin
            state_next = F_OP;
        end else begin
            case (state)
                F_OP:  state_next = L_OP;
`ifdef FETCH_IMM_EN
                L_OP:  state_next = bus.mem_rd_data[7] ? F_IMM : VALID;
                F_IMM: state_next = L_IMM;
                L_IMM: state_next = VALID;
`else
                L_OP:  state_next = VALID;
`endif
                VALID: state_next = bus.instr_ready ? F_OP : VALID;
                default: state_next = F_OP;
            endcase
        end
    end

    always_comb begin
        bus.mem_addr    = pc;
        bus.instr_valid = (state == VALID);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc    <= RESET_PC;
            op_q  <= 8'h00;
            pc_q  <= 8'h00;
`ifdef FETCH_IMM_EN
            imm_q <= 8'h00;
            len_q <= 1'b0;
`endif
        end else if (bus.jmp_en) begin
            pc <= bus.jmp_addr;
        end else begin
            case (state)
                L_OP: begin
                    op_q  <= bus.mem_rd_data;
                    pc_q  <= pc;
                    pc    <= pc + 8'd1;
`ifdef FETCH_IMM_EN
                    imm_q <= 8'h00;
                    len_q <= 1'b0;
`endif
                end
`ifdef FETCH_IMM_EN
                L_IMM: begin
                    imm_q <= bus.mem_rd_data;
                    len_q <= 1'b1;
                    pc    <= pc + 8'd1;
                end
`endif
                default: ;
            endcase
        end
    end

    assign bus.instr_op  = op_q;
    assign bus.instr_pc  = pc_q;
`ifdef FETCH_IMM_EN
    assign bus.instr_imm = imm_q;
    assign bus.instr_len = len_q;
`else
    assign bus.instr_imm = 8'h00;
    assign bus.instr_len = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit with a registered-read program memory
module tb_fetch_unit;

    typedef struct packed {
        logic [7:0] op;
        logic [7:0] imm;
        logic [7:0] pc;
        logic       len;
    } instr_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] mem [0:255];
    instr_t     sb[$];
    int         checks = 0;
    int         errors = 0;

    fetch_unit_if bus ();

    fetch_unit #(.RESET_PC(8'h00)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) bus.mem_rd_data <= mem[bus.mem_addr];

    function automatic instr_t mk(input logic [7:0] op, input logic [7:0] imm,
                                  input logic [7:0] pc, input logic len);
        instr_t t;
        t.op  = op;
        t.imm = imm;
        t.pc  = pc;
        t.len = len;
        return t;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset(input bit with_checks);
        rst = 1'b1;
        bus.instr_ready = 1'b0;
        bus.jmp_en = 1'b0;
        sb.delete();
        tick();
        tick();
        if (with_checks) begin
            check8("reset_valid", {7'd0, bus.instr_valid}, 8'h00);
            check8("reset_op", bus.instr_op, 8'h00);
            check8("reset_imm", bus.instr_imm, 8'h00);
            check8("reset_pc", bus.instr_pc, 8'h00);
            check8("reset_len", {7'd0, bus.instr_len}, 8'h00);
            check8("reset_mem_addr", bus.mem_addr, 8'h00);
        end
        rst = 1'b0;
    endtask

    task automatic wait_size(input int target, input string name);
        int left = 200;
        while (sb.size() > target && left > 0) begin
            tick();
            left--;
        end
        if (sb.size() > target) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout with %0d pending, expected %0d", name, sb.size(), target);
            sb.delete();
        end
    endtask

    // Monitor: compares the presented instruction with the head of the scoreboard every
    // valid cycle (so stalls must hold steady) and retires it on the handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && bus.instr_valid) begin
                if (sb.size() == 0) begin
                    if (bus.instr_ready) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_instr: got op %h pc %h, expected none",
                                 bus.instr_op, bus.instr_pc);
                    end
                end else begin
                    checks++;
                    if (bus.instr_op !== sb[0].op || bus.instr_imm !== sb[0].imm ||
                        bus.instr_pc !== sb[0].pc || bus.instr_len !== sb[0].len) begin
                        errors++;
                        $display("FAIL instr: got op %h imm %h pc %h len %b, expected op %h imm %h pc %h len %b",
                                 bus.instr_op, bus.instr_imm, bus.instr_pc, bus.instr_len,
                                 sb[0].op, sb[0].imm, sb[0].pc, sb[0].len);
                    end
                    if (bus.instr_ready) void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[0] = 8'h64; mem[1] = 8'h10; mem[2] = 8'h93;
        mem[3] = 8'h58; mem[4] = 8'hFF; mem[5] = 8'h05;
        bus.instr_ready = 1'b0;
        bus.jmp_en = 1'b0;
        bus.jmp_addr = 8'h00;

        // Stream
        do_reset(1'b1);
        sb.push_back(mk(8'h64, 8'h00, 8'h00, 1'b0));
        sb.push_back(mk(8'h10, 8'h00, 8'h01, 1'b0));
`ifdef FETCH_IMM_EN
        sb.push_back(mk(8'h93, 8'h58, 8'h02, 1'b1));
        sb.push_back(mk(8'hFF, 8'h05, 8'h04, 1'b1));
`else
        sb.push_back(mk(8'h93, 8'h00, 8'h02, 1'b0));
        sb.push_back(mk(8'h58, 8'h00, 8'h03, 1'b0));
`endif
        bus.instr_ready = 1'b1;
        wait_size(0, "stream");
        bus.instr_ready = 1'b0;

        // Backpressure on 0x93
        do_reset(1'b0);
        sb.push_back(mk(8'h64, 8'h00, 8'h00, 1'b0));
        sb.push_back(mk(8'h10, 8'h00, 8'h01, 1'b0));
`ifdef FETCH_IMM_EN
        sb.push_back(mk(8'h93, 8'h58, 8'h02, 1'b1));
        sb.push_back(mk(8'hFF, 8'h05, 8'h04, 1'b1));
`else
        sb.push_back(mk(8'h93, 8'h00, 8'h02, 1'b0));
        sb.push_back(mk(8'h58, 8'h00, 8'h03, 1'b0));
`endif
        bus.instr_ready = 1'b1;
        wait_size(2, "bp_head");
        bus.instr_ready = 1'b0;
        for (int i = 0; i < 10 && !bus.instr_valid; i++) tick();
        for (int i = 0; i < 5; i++) begin
            check8("bp_valid", {7'd0, bus.instr_valid}, 8'h01);
`ifdef FETCH_IMM_EN
            check8("bp_mem_addr", bus.mem_addr, 8'h04);
`else
            check8("bp_mem_addr", bus.mem_addr, 8'h03);
`endif
            tick();
        end
        bus.instr_ready = 1'b1;
        wait_size(0, "bp_tail");
        bus.instr_ready = 1'b0;

        // Jump to 0x04 during L_OP of the first fetch
        do_reset(1'b0);
`ifdef FETCH_IMM_EN
        sb.push_back(mk(8'hFF, 8'h05, 8'h04, 1'b1));
`else
        sb.push_back(mk(8'hFF, 8'h00, 8'h04, 1'b0));
        sb.push_back(mk(8'h05, 8'h00, 8'h05, 1'b0));
`endif
        tick();
        bus.jmp_en = 1'b1;
        bus.jmp_addr = 8'h04;
        bus.instr_ready = 1'b1;
        tick();
        bus.jmp_en = 1'b0;
        check8("jmp_mem_addr", bus.mem_addr, 8'h04);
        check8("jmp_valid_j1", {7'd0, bus.instr_valid}, 8'h00);
        tick();
        check8("jmp_valid_j2", {7'd0, bus.instr_valid}, 8'h00);
        wait_size(0, "jump");
        bus.instr_ready = 1'b0;

        // Wrap: two-byte opcode at 0xFF
        mem[8'hFF] = 8'h80;
        do_reset(1'b0);
`ifdef FETCH_IMM_EN
        sb.push_back(mk(8'h80, 8'h64, 8'hFF, 1'b1));
        sb.push_back(mk(8'h10, 8'h00, 8'h01, 1'b0));
`else
        sb.push_back(mk(8'h80, 8'h00, 8'hFF, 1'b0));
        sb.push_back(mk(8'h64, 8'h00, 8'h00, 1'b0));
`endif
        bus.jmp_en = 1'b1;
        bus.jmp_addr = 8'hFF;
        tick();
        bus.jmp_en = 1'b0;
        check8("wrap_mem_addr", bus.mem_addr, 8'hFF);
        bus.instr_ready = 1'b1;
        wait_size(0, "wrap");
        bus.instr_ready = 1'b0;

        // Reset while fetching 0x93
        do_reset(1'b0);
        sb.push_back(mk(8'h64, 8'h00, 8'h00, 1'b0));
        sb.push_back(mk(8'h10, 8'h00, 8'h01, 1'b0));
        bus.instr_ready = 1'b1;
        wait_size(0, "rst_pre");
        bus.instr_ready = 1'b0;
`ifdef FETCH_IMM_EN
        tick(); tick(); tick();
        check8("rst_limm_mem_addr", bus.mem_addr, 8'h03);
`else
        tick();
        check8("rst_lop_mem_addr", bus.mem_addr, 8'h02);
`endif
        rst = 1'b1;
        tick();
        check8("rst_mid_valid", {7'd0, bus.instr_valid}, 8'h00);
        check8("rst_mid_mem_addr", bus.mem_addr, 8'h00);
        rst = 1'b0;
        sb.push_back(mk(8'h64, 8'h00, 8'h00, 1'b0));
        bus.instr_ready = 1'b1;
        wait_size(0, "rst_post");
        bus.instr_ready = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
